// File: rtl/time_counter_pkg.sv
// Shared constants for the time_counter block: operate codes, handshake
// FSM encoding and the per-field moduli of the BCD counters.
package time_counter_pkg;

  localparam logic [1:0] OP_NONE     = 2'b00;
  localparam logic [1:0] OP_SEC_ZERO = 2'b01;
  localparam logic [1:0] OP_MIN_ADD  = 2'b10;
  localparam logic [1:0] OP_RESET    = 2'b11;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_CLR = 1'b1;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

endpackage

// File: rtl/time_counter_if.sv
// Command/time bus between the button encoder side and the time counter.
interface time_counter_if;
  logic       tick;
  logic [1:0] operate;
  logic       encoder_reset;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       hour_strobe;

  modport master (
    output tick, operate,
    input  encoder_reset, sec_bcd, min_bcd, hour_bcd, hour_strobe
  );

  modport slave (
    input  tick, operate,
    output encoder_reset, sec_bcd, min_bcd, hour_bcd, hour_strobe
  );
endinterface

// File: rtl/time_counter_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULUS-1 -> 00. o_carry is combinational:
// high when i_inc would wrap the counter this cycle.
module bcd_mod_counter #(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clear,
  output logic [7:0] o_value,
  output logic       o_carry
);

  localparam logic [3:0] LAST_T = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] LAST_U = 4'((MODULUS - 1) % 10);

  logic [3:0] r_tens;
  logic [3:0] r_units;
  logic       w_at_last;

  assign w_at_last = (r_tens == LAST_T) && (r_units == LAST_U);
  assign o_carry   = i_inc && w_at_last;
  assign o_value   = {r_tens, r_units};

  // Digit update: clear dominates increment; units 9 carries into tens.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else if (i_inc) begin
      if (w_at_last) begin
        r_tens  <= 4'd0;
        r_units <= 4'd0;
      end else if (r_units == 4'd9) begin
        r_tens  <= r_tens + 4'd1;
        r_units <= 4'd0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_counter.sv
// Hours/minutes/seconds BCD time counter with a one-shot command handshake
// towards the upstream button encoder.
module time_counter
  import time_counter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  time_counter_if.slave bus
);

  logic [0:0] r_state;
  logic       r_enc_rst;
  logic       r_hour_strobe;

  logic       w_accept;
  logic       w_op_reset;
  logic       w_op_sec_zero;
  logic       w_op_min_add;
  logic       w_tick_eff;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic       w_min_inc;
  logic       w_hour_inc;
  logic       w_unused_day_carry;
  logic [7:0] w_sec;
  logic [7:0] w_min;
  logic [7:0] w_hour;

  assign w_accept      = (r_state == ST_IDLE) && (bus.operate != OP_NONE);
  assign w_op_reset    = w_accept && (bus.operate == OP_RESET);
  assign w_op_sec_zero = w_accept && (bus.operate == OP_SEC_ZERO);
  assign w_op_min_add  = w_accept && (bus.operate == OP_MIN_ADD);

  // Zeroing commands swallow a coincident tick.
  assign w_tick_eff = bus.tick && !w_op_reset && !w_op_sec_zero;

  // Second carry and minute_add merge into a single +1; a minute wrap caused
  // by minute_add never reaches the hours.
  assign w_min_inc  = w_sec_carry || w_op_min_add;
  assign w_hour_inc = w_min_carry && !w_op_min_add;

  bcd_mod_counter #(.MODULUS(SEC_MOD)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_tick_eff),
    .i_clear (w_op_reset || w_op_sec_zero),
    .o_value (w_sec),
    .o_carry (w_sec_carry)
  );

  bcd_mod_counter #(.MODULUS(MIN_MOD)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_min_inc),
    .i_clear (w_op_reset),
    .o_value (w_min),
    .o_carry (w_min_carry)
  );

  bcd_mod_counter #(.MODULUS(HOUR_MOD)) u_hour (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hour_inc),
    .i_clear (w_op_reset),
    .o_value (w_hour),
    .o_carry (w_unused_day_carry)
  );

  // Handshake FSM, acknowledge pulse and hour strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_enc_rst     <= 1'b0;
      r_hour_strobe <= 1'b0;
    end else begin
      r_enc_rst     <= w_accept;
      r_hour_strobe <= w_hour_inc;
      if (r_state == ST_IDLE) begin
        if (w_accept) r_state <= ST_WAIT_CLR;
      end else begin
        if (bus.operate == OP_NONE) r_state <= ST_IDLE;
      end
    end
  end

  assign bus.sec_bcd       = w_sec;
  assign bus.min_bcd       = w_min;
  assign bus.hour_bcd      = w_hour;
  assign bus.encoder_reset = r_enc_rst;
  assign bus.hour_strobe   = r_hour_strobe;

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port tick, input, 1, one-clk-wide 1 Hz enable strobe.
REQ-004 SHALL have port operate, input, 2, command code from the upstream button encoder: 00 none, 10 minute_add, 01 sec_to_zero, 11 time reset.
REQ-005 SHALL have port encoder_reset, output, 1, one-clk acknowledge pulse that clears the upstream encoder's held command.
REQ-006 SHALL have port sec_bcd, output, 8, seconds as two BCD digits {tens, units}, range 00-59.
REQ-007 SHALL have port min_bcd, output, 8, minutes as two BCD digits, range 00-59.
REQ-008 SHALL have port hour_bcd, output, 8, hours as two BCD digits, range 00-23.
REQ-009 SHALL have port hour_strobe, output, 1, one-clk pulse on a tick-driven rollover to mm:ss = 00:00.

Function
REQ-010 Counter: a tick with no command SHALL advance seconds by 1; 59->00 SHALL carry +1 minute; minute 59->00 SHALL carry +1 hour; hour 23->00.
REQ-011 Arithmetic: SHALL be pure BCD; units 9->0 carries to tens; no binary-to-BCD conversion; non-BCD values are unreachable.
REQ-012 Handshake FSM states: IDLE, WAIT_CLR.
REQ-013 IDLE with operate != 00: SHALL execute the command in that clock edge, assert encoder_reset for exactly the next cycle, and go to WAIT_CLR.
REQ-014 WAIT_CLR: operate SHALL be ignored; return to IDLE on the first cycle operate == 00; encoder_reset SHALL stay low.
REQ-015 Command latency: register update and the encoder_reset pulse SHALL both be visible 1 clk after operate is sampled non-zero.
REQ-016 minute_add (10): minutes +1 mod 60; SHALL NOT carry into hours; seconds unaffected except per REQ-019.
REQ-017 sec_to_zero (01): seconds := 00; a coincident tick SHALL be discarded; minutes/hours unchanged.
REQ-018 reset (11): hour, min, sec := 00:00:00; a coincident tick SHALL be discarded.
REQ-019 Tick coincident with minute_add: seconds advance normally; if seconds wrap 59->00, minutes SHALL still advance by exactly 1 (carry and command merge, no double increment); no hour carry from this event.
REQ-020 hour_strobe SHALL fire only on a tick-driven 59:59 -> 00:00 transition, never on command-driven changes.
REQ-021 A command held non-zero for many cycles SHALL execute exactly once.
REQ-022 If operate changes between non-zero codes during WAIT_CLR, no additional command SHALL execute.

Reset
REQ-023 On rst=1 at a clock edge: sec_bcd, min_bcd, hour_bcd = 8'h00; encoder_reset = 0; hour_strobe = 0; FSM = IDLE.
REQ-024 rst SHALL take priority over tick and operate in the same cycle; a command pending at reset SHALL be dropped without acknowledge.
REQ-025 After rst deasserts, a still-non-zero operate SHALL be accepted as a new command from IDLE.

Structure
REQ-026 Shared package SHALL hold operate code constants (OP_NONE, OP_MIN_ADD, OP_SEC_ZERO, OP_RESET), FSM state encoding, and moduli 60/24.
REQ-027 One sub-module, bcd_mod_counter, SHALL implement a 2-digit BCD counter with parameter modulus, inputs inc/clear, output value and carry; instantiated three times (sec, min, hour).

Verification
REQ-028 Reset then 3661 ticks -> hour_bcd=01, min_bcd=01, sec_bcd=01; hour_strobe seen exactly once.
REQ-029 Time 00:59:30, operate=10 held 20 clks -> min_bcd=00, hour_bcd=00 unchanged, one encoder_reset pulse, no hour_strobe.
REQ-030 Time 12:34:56, operate=01 coincident with tick -> sec_bcd=00, min_bcd=34, hour_bcd=12 next clk.
REQ-031 Time 23:59:59, tick -> 00:00:00, hour_strobe=1 for one clk.
REQ-032 Time 10:20:59, operate=10 with coincident tick -> 10:21:00.
REQ-033 operate=11 sampled, rst asserted the following cycle while operate still 11 -> all outputs 00, no encoder_reset; after rst drops, command re-executes with one encoder_reset pulse.
